pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Branch-side bundle between the control decoder/ALU and the PC sequencer,
// plus the sequencer's fetch address and run status.
interface pc_sequencer_if #(
  parameter int PC_WIDTH     = 10,
  parameter int OFFSET_WIDTH = 8,
  parameter int CYC_WIDTH    = 16
);
  logic                    Start;
  logic [1:0]              PCRegSelect;
  logic                    JumpEqual;
  logic                    JumpNotEqual;
  logic                    StorePC;
  logic                    OffsetEn;
  logic [OFFSET_WIDTH-1:0] Offset;
  logic                    Zero;
  logic                    Ack;
  logic [PC_WIDTH-1:0]     ProgCounter;
  logic                    Busy;
  logic                    Done;
  logic [CYC_WIDTH-1:0]    CycleCount;

  modport master (
    output Start, PCRegSelect, JumpEqual, JumpNotEqual, StorePC, OffsetEn,
           Offset, Zero, Ack,
    input  ProgCounter, Busy, Done, CycleCount
  );

  modport slave (
    input  Start, PCRegSelect, JumpEqual, JumpNotEqual, StorePC, OffsetEn,
           Offset, Zero, Ack,
    output ProgCounter, Busy, Done, CycleCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and branch resolution: IDLE/RUN/HALT sequencing, three PC
// link registers, conditional jumps through them and a saturating run counter.
module pc_sequencer #(
  parameter int PC_WIDTH     = 10,
  parameter int OFFSET_WIDTH = 8,
  parameter int START_ADDR   = 0,
  parameter int CYC_WIDTH    = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]  START_PC = PC_WIDTH'(START_ADDR);
  localparam logic [CYC_WIDTH-1:0] CYC_MAX  = '1;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  pcreg_q [1:3];
  logic [PC_WIDTH-1:0]  pcreg_d [1:3];
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 taken;
  logic [PC_WIDTH-1:0]  jump_tgt;
  logic [PC_WIDTH-1:0]  off_ext;
  logic [PC_WIDTH-1:0]  store_val;

  assign off_ext   = PC_WIDTH'($signed(bus.Offset[OFFSET_WIDTH-1:0]));
  assign store_val = bus.OffsetEn ? pc_q + off_ext : pc_q;

  // Select 00 never names a register, so it can never produce a taken jump.
  assign taken = (bus.PCRegSelect != 2'b00) &&
                 ((bus.JumpEqual && bus.Zero) || (bus.JumpNotEqual && !bus.Zero));

  always_comb begin
    jump_tgt = '0;
    case (bus.PCRegSelect)
      2'd1:    jump_tgt = pcreg_q[1];
      2'd2:    jump_tgt = pcreg_q[2];
      2'd3:    jump_tgt = pcreg_q[3];
      default: jump_tgt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    for (int i = 1; i <= 3; i++) begin
      pcreg_d[i] = pcreg_q[i];
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
          cyc_d   = '0;
        end
      end
      ST_RUN: begin
        if (cyc_q != CYC_MAX) begin
          cyc_d = cyc_q + 1'b1;
        end
        if (bus.Ack) begin
          state_d = ST_HALT;
        end else if (taken) begin
          pc_d = jump_tgt;
        end else begin
          pc_d = pc_q + 1'b1;
        end
        // The jump above read the old link value; the store lands at the edge.
        for (int i = 1; i <= 3; i++) begin
          if (bus.StorePC && (bus.PCRegSelect == 2'(i))) begin
            pcreg_d[i] = store_val;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 1; i <= 3; i++) begin
        pcreg_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 1; i <= 3; i++) begin
        pcreg_q[i] <= pcreg_d[i];
      end
    end
  end

  assign bus.ProgCounter = pc_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.CycleCount  = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_pc_sequencer;
  localparam int PCW   = 10;
  localparam int OFW   = 8;
  localparam int CYW   = 16;
  localparam int CYW_S = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  pc_sequencer_if #(.PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .CYC_WIDTH(CYW))   bus ();
  pc_sequencer_if #(.PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .CYC_WIDTH(CYW_S)) bus_s ();

  pc_sequencer #(.PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .START_ADDR(0), .CYC_WIDTH(CYW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  // Narrow-counter copy fed the same inputs, so counter saturation is reachable.
  pc_sequencer #(.PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .START_ADDR(0), .CYC_WIDTH(CYW_S)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_s)
  );

  assign bus_s.Start        = bus.Start;
  assign bus_s.PCRegSelect  = bus.PCRegSelect;
  assign bus_s.JumpEqual    = bus.JumpEqual;
  assign bus_s.JumpNotEqual = bus.JumpNotEqual;
  assign bus_s.StorePC      = bus.StorePC;
  assign bus_s.OffsetEn     = bus.OffsetEn;
  assign bus_s.Offset       = bus.Offset;
  assign bus_s.Zero         = bus.Zero;
  assign bus_s.Ack          = bus.Ack;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       je, jne, st, oen;
    logic [7:0] off;
    logic       z, ack;
    int         pc, busy, done, cyc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  bit m_run, m_halt;
  int m_pc, m_cyc;
  int m_reg[4];

  function automatic vec_t mk(logic start, logic [1:0] sel, logic je, logic jne, logic st,
                              logic oen, logic [7:0] off, logic z, logic ack,
                              int pc, int busy, int done, int cyc);
    vec_t v;
    v.start = start; v.sel = sel; v.je = je; v.jne = jne; v.st = st; v.oen = oen;
    v.off = off; v.z = z; v.ack = ack;
    v.pc = pc; v.busy = busy; v.done = done; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int pc, input int busy, input int done, input int cyc);
    $display("%s: pc=%0d busy=%0d done=%0d cyc=%0d (exp pc=%0d busy=%0d done=%0d cyc=%0d)",
             tag, bus.ProgCounter, bus.Busy, bus.Done, bus.CycleCount, pc, busy, done, cyc);
    chk({tag, ".pc"},   int'(bus.ProgCounter), pc);
    chk({tag, ".busy"}, int'(bus.Busy), busy);
    chk({tag, ".done"}, int'(bus.Done), done);
    chk({tag, ".cyc"},  int'(bus.CycleCount), cyc);
  endtask

  task automatic drive(input logic start, input logic [1:0] sel, input logic je, input logic jne,
                       input logic st, input logic oen, input logic [7:0] off,
                       input logic z, input logic ack);
    bus.Start = start; bus.PCRegSelect = sel; bus.JumpEqual = je; bus.JumpNotEqual = jne;
    bus.StorePC = st; bus.OffsetEn = oen; bus.Offset = off; bus.Zero = z; bus.Ack = ack;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input logic start, input logic [1:0] sel, input logic je, input logic jne,
                     input logic st, input logic oen, input logic [7:0] off,
                     input logic z, input logic ack);
    drive(start, sel, je, jne, st, oen, off, z, ack);
    step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    Reset_n = 1'b0;
    step();
    step();
    check_out("reset", 0, 0, 0, 0);
    Reset_n = 1'b1;
    m_run = 0; m_halt = 0; m_pc = 0; m_cyc = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endtask

  // One clock of the reference model, applying the rules directly.
  task automatic model_step(input bit start, input int sel, input bit je, input bit jne,
                            input bit st, input bit oen, input int off8, input bit z, input bit ack);
    int  tgt, soff;
    bit  tk;
    if (m_run) begin
      tgt  = m_reg[sel];
      tk   = (sel != 0) && ((je && z) || (jne && !z));
      soff = (off8 >= 128) ? off8 - 256 : off8;
      if (st && sel != 0) m_reg[sel] = (m_pc + (oen ? soff : 0)) & 1023;
      m_cyc++;
      if (ack) begin
        m_run = 0; m_halt = 1;
      end else if (tk) begin
        m_pc = tgt;
      end else begin
        m_pc = (m_pc + 1) & 1023;
      end
    end else if (start) begin
      m_run = 1; m_halt = 0; m_pc = 0; m_cyc = 0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- table-driven vectors ----------------
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,0,0,  0,1,0,0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,0, k,1,0,k));
    tbl.push_back(mk(0,1,0,0,1,0,8'h00,0,0,  6,1,0,6));   // PCreg1 <= 5
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,0,  7,1,0,7));
    tbl.push_back(mk(0,0,1,0,0,0,8'h00,1,0,  8,1,0,8));   // sel 00: not taken
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,0,  9,1,0,9));
    tbl.push_back(mk(0,1,0,1,0,0,8'h00,0,0,  5,1,0,10));  // JNE, Zero=0 taken
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,0, 6+k,1,0,11+k));
    tbl.push_back(mk(0,1,0,1,0,0,8'h00,1,0, 10,1,0,15));  // JNE, Zero=1 not taken
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,0,0, 11,1,0,16));  // Start ignored in RUN
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,0, 12,1,0,17));
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,0,1, 12,0,1,18));  // Ack -> HALT
    tbl.push_back(mk(0,1,0,1,1,0,8'h00,0,1, 12,0,1,18));  // ignored in HALT
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,0,0,  0,1,0,0));   // restart
    tbl.push_back(mk(0,1,1,0,0,0,8'h00,1,0,  5,1,0,1));   // PCreg1 retained
    tbl.push_back(mk(0,1,1,1,1,1,8'h03,0,0,  5,1,0,2));   // jump reads old, store 8
    tbl.push_back(mk(0,1,1,0,0,0,8'h00,1,0,  8,1,0,3));
    tbl.push_back(mk(0,2,0,0,1,0,8'h00,0,1,  8,0,1,4));   // store with Ack
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,0,0,  0,1,0,0));
    tbl.push_back(mk(0,2,1,0,0,0,8'h00,1,0,  8,1,0,1));

    do_reset();
    foreach (tbl[i]) begin
      run(tbl[i].start, tbl[i].sel, tbl[i].je, tbl[i].jne, tbl[i].st, tbl[i].oen,
          tbl[i].off, tbl[i].z, tbl[i].ack);
      check_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].busy, tbl[i].done, tbl[i].cyc);
    end

    // ---------------- signed offsets ----------------
    do_reset();
    run(1,0,0,0,0,0,8'h00,0,0);
    run(0,3,0,0,1,1,8'd20,0,0);               // PCreg3 = 20
    run(0,3,1,0,0,0,8'h00,1,0);
    check_out("jmp20", 20, 1, 0, 2);
    run(0,2,0,0,1,1,8'hFC,0,0);               // PCreg2 = 20-4
    run(0,2,1,0,0,0,8'h00,1,0);
    check_out("pcreg2_neg", 16, 1, 0, 4);
    run(0,1,0,0,1,1,8'h7F,0,0);               // PCreg1 = 143
    run(0,1,1,0,0,0,8'h00,1,0);
    run(0,1,0,0,1,1,8'h61,0,0);               // PCreg1 = 240
    run(0,1,1,0,0,0,8'h00,1,0);
    check_out("pc_f0", 240, 1, 0, 8);
    run(0,3,0,0,1,1,8'h7F,0,0);               // PCreg3 = 0x16F
    run(0,3,1,0,0,0,8'h00,1,0);
    check_out("pcreg3_16f", 367, 1, 0, 10);

    // ---------------- wrap and async reset ----------------
    do_reset();
    run(1,0,0,0,0,0,8'h00,0,0);
    run(0,1,0,0,1,1,8'hFF,0,0);               // PCreg1 = 0-1 = 1023
    run(0,1,1,0,0,0,8'h00,1,0);
    check_out("pc1023", 1023, 1, 0, 2);
    run(0,0,0,0,0,0,8'h00,0,0);
    check_out("pc_wrap", 0, 1, 0, 3);
    run(0,1,0,0,1,1,8'd30,0,0);               // PCreg1 = 30
    run(0,2,0,0,1,1,8'd39,0,0);               // PCreg2 = 40
    run(0,2,1,0,0,0,8'h00,1,0);
    check_out("pc40", 40, 1, 0, 6);
    #2;
    drive(1,0,0,0,0,0,8'h00,0,0);
    Reset_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    drive(0,0,0,0,0,0,8'h00,0,0);
    Reset_n = 1'b1;
    step();
    check_out("no_start_latch", 0, 0, 0, 0);
    run(1,0,0,0,0,0,8'h00,0,0);
    run(0,1,1,0,0,0,8'h00,1,0);               // PCreg1 cleared -> jump to 0
    check_out("pcreg1_cleared", 0, 1, 0, 1);

    // ---------------- randomized vs. model ----------------
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit st_r, ack_r, je_r, jne_r, st_i, oen_r, z_r;
      int sel_r, off_r, exp_c, exp_cs;
      st_r  = ($urandom_range(0, 15) == 0);
      sel_r = $urandom_range(0, 3);
      je_r  = ($urandom_range(0, 3) == 0);
      jne_r = ($urandom_range(0, 3) == 0);
      st_i  = ($urandom_range(0, 2) == 0);
      oen_r = 1'($urandom_range(0, 1));
      off_r = $urandom_range(0, 255);
      z_r   = 1'($urandom_range(0, 1));
      ack_r = ($urandom_range(0, 24) == 0);
      run(st_r, 2'(sel_r), je_r, jne_r, st_i, oen_r, 8'(off_r), z_r, ack_r);
      model_step(st_r, sel_r, je_r, jne_r, st_i, oen_r, off_r, z_r, ack_r);
      exp_c  = (m_cyc > 65535) ? 65535 : m_cyc;
      exp_cs = (m_cyc > 15) ? 15 : m_cyc;
      check_out($sformatf("rnd%0d", n), m_pc, int'(m_run), int'(m_halt), exp_c);
      chk($sformatf("rnd%0d.cyc_sat", n), int'(bus_s.CycleCount), exp_cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
